// File: rtl/tmr_codec_pipe_if.sv
// Bundle of the flow-control, payload and fault-reporting signals of
// tmr_codec_pipe.
//   master : the producer/consumer side (drives in_valid, data_in, bit_flip,
//            bypass, err_clr, out_ready; observes everything else)
//   slave  : the codec itself
// The parameters must match those of the tmr_codec_pipe instance it feeds.
interface tmr_codec_pipe_if #(
  parameter int DATA_W   = 16,
  parameter int N_COPIES = 3,
  parameter int CNT_W    = 16
);
  localparam int CB_W = $clog2(DATA_W + 1);

  logic                         in_valid;
  logic                         in_ready;
  logic [DATA_W-1:0]            data_in;
  logic [N_COPIES*DATA_W-1:0]   bit_flip;
  logic                         bypass;
  logic                         err_clr;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_W-1:0]            data_out;
  logic [CB_W-1:0]              corr_bits;
  logic [N_COPIES-1:0]          copy_fault;
  logic [CNT_W-1:0]             word_err_cnt;

  modport master (
    output in_valid, data_in, bit_flip, bypass, err_clr, out_ready,
    input  in_ready, out_valid, data_out, corr_bits, copy_fault, word_err_cnt
  );

  modport slave (
    input  in_valid, data_in, bit_flip, bypass, err_clr, out_ready,
    output in_ready, out_valid, data_out, corr_bits, copy_fault, word_err_cnt
  );
endinterface

// File: rtl/tmr_codec_pipe.sv
// Two-stage pipelined TMR coder/decoder with fault injection.
//   S1 holds N_COPIES replicas of the accepted word. On the S1->S2 advance the
//   fault mask is XORed onto the replicas, each bit is majority-voted, and the
//   vote (or raw copy 0 in bypass mode) lands in S2 together with the number of
//   disagreeing bit positions.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - tmr_codec_pipe_if.slave: valid/ready input and output handshakes,
//          data_in/bit_flip/bypass/err_clr controls, data_out, corr_bits,
//          sticky copy_fault map and saturating word_err_cnt.
module tmr_codec_pipe #(
  parameter int DATA_W   = 16,
  parameter int N_COPIES = 3,
  parameter int CNT_W    = 16
) (
  input  logic            clk,
  input  logic            rst,
  tmr_codec_pipe_if.slave bus
);
  localparam int CB_W = $clog2(DATA_W + 1);
  localparam int PC_W = $clog2(N_COPIES + 1);
  localparam int RW   = N_COPIES * DATA_W;

  logic              s1_valid_q, s1_valid_d;
  logic [RW-1:0]     s1_copies_q, s1_copies_d;
  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_data_q, s2_data_d;
  logic [CB_W-1:0]   s2_corr_q, s2_corr_d;
  logic [N_COPIES-1:0] fault_q, fault_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              s2_free, in_xfer, out_xfer, advance;
  logic [RW-1:0]     corrupted;
  logic [DATA_W-1:0] vote, disagree;
  logic [N_COPIES-1:0] fault_now;
  logic [CB_W-1:0]   corr_count;

  assign s2_free   = !s2_valid_q || bus.out_ready;
  assign in_xfer   = bus.in_valid && bus.in_ready;
  assign out_xfer  = s2_valid_q && bus.out_ready;
  assign advance   = s1_valid_q && s2_free;
  // The mask only matters in the cycle the word leaves S1.
  assign corrupted = s1_copies_q ^ bus.bit_flip;

  // Per-bit majority vote and disagreement detection.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
    logic [N_COPIES-1:0] col;
    logic [PC_W-1:0]     ones;
    for (genvar gk = 0; gk < N_COPIES; gk++) begin : g_col
      assign col[gk] = corrupted[gk*DATA_W + gi];
    end
    always_comb begin
      ones = '0;
      for (int k = 0; k < N_COPIES; k++) ones = ones + PC_W'(col[k]);
    end
    assign vote[gi]     = ones > PC_W'(N_COPIES / 2);
    // Disagreement: neither all zeros nor all ones.
    assign disagree[gi] = (|col) && !(&col);
  end

  // A copy is faulty if it differs from the vote anywhere, bypass or not.
  for (genvar gi = 0; gi < N_COPIES; gi++) begin : g_copy
    assign fault_now[gi] = |(corrupted[gi*DATA_W +: DATA_W] ^ vote);
  end

  always_comb begin
    corr_count = '0;
    for (int i = 0; i < DATA_W; i++) corr_count = corr_count + CB_W'(disagree[i]);
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_copies_d = s1_copies_q;
    s2_valid_d  = s2_valid_q;
    s2_data_d   = s2_data_q;
    s2_corr_d   = s2_corr_q;
    fault_d     = fault_q;
    cnt_d       = cnt_q;

    if (in_xfer) begin
      s1_valid_d  = 1'b1;
      s1_copies_d = {N_COPIES{bus.data_in}};
    end else if (advance) begin
      s1_valid_d  = 1'b0;
    end

    if (advance) begin
      s2_valid_d = 1'b1;
      s2_data_d  = bus.bypass ? corrupted[DATA_W-1:0] : vote;
      s2_corr_d  = corr_count;
      fault_d    = fault_q | fault_now;
    end else if (out_xfer) begin
      s2_valid_d = 1'b0;
    end

    if (out_xfer && (s2_corr_q != '0) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end

    // Clear takes priority over a same-cycle set or increment.
    if (bus.err_clr) begin
      fault_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_copies_q <= '0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_corr_q   <= '0;
      fault_q     <= '0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_copies_q <= s1_copies_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_corr_q   <= s2_corr_d;
      fault_q     <= fault_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready     = !s1_valid_q || s2_free;
  assign bus.out_valid    = s2_valid_q;
  assign bus.data_out     = s2_data_q;
  assign bus.corr_bits    = s2_corr_q;
  assign bus.copy_fault   = fault_q;
  assign bus.word_err_cnt = cnt_q;
endmodule

// File: tb/tb_tmr_codec_pipe.sv
// Testbench for tmr_codec_pipe: directed vectors, a word-level reference
// model feeding a scoreboard checked every cycle, plus literal expectations.
// The model evaluates each word with the bit_flip/bypass present when the word
// is accepted, so directed tests hold those steady until the word leaves.
// err_clr is only pulsed with at most one word in flight.
module tb_tmr_codec_pipe;
  localparam int W = 16;
  localparam int N = 3;

  typedef struct packed {
    logic [W-1:0] data;
    logic [4:0]   corr;
    logic [N-1:0] fault;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tmr_codec_pipe_if #(.DATA_W(W), .N_COPIES(N), .CNT_W(16)) bus ();
  tmr_codec_pipe_if #(.DATA_W(W), .N_COPIES(N), .CNT_W(2))  bus2 ();

  tmr_codec_pipe #(.DATA_W(W), .N_COPIES(N), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  tmr_codec_pipe #(.DATA_W(W), .N_COPIES(N), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];
  exp_t fr;
  logic [N-1:0] acc_fault = '0;
  logic [N-1:0] fexp;
  int cnt_m = 0;
  int out_count = 0;
  logic [W-1:0] last_data = '0;
  logic [4:0]   last_corr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word-level reference: replicate, corrupt, vote by popcount.
  function automatic exp_t model(input logic [W-1:0] d, input logic [N*W-1:0] f, input logic b);
    exp_t e;
    logic [W-1:0] c [N];
    logic [W-1:0] v;
    int ones;
    int ncorr;
    for (int k = 0; k < N; k++) c[k] = d ^ f[k*W +: W];
    v = '0;
    ncorr = 0;
    for (int i = 0; i < W; i++) begin
      ones = 0;
      for (int k = 0; k < N; k++) ones += int'(c[k][i]);
      v[i] = (ones * 2 > N);
      if (ones != 0 && ones != N) ncorr++;
    end
    e.data = b ? c[0] : v;
    e.corr = 5'(ncorr);
    for (int k = 0; k < N; k++) e.fault[k] = (c[k] != v);
    return e;
  endfunction

  // Per-cycle compare against the scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      acc_fault = '0;
      cnt_m = 0;
    end else begin
      fexp = acc_fault;
      if (bus.out_valid && sb.size() > 0) fexp = acc_fault | sb[0].fault;
      chk("copy_fault", 64'(bus.copy_fault), 64'(fexp));
      chk("word_err_cnt", 64'(bus.word_err_cnt), 64'(cnt_m));
      if (bus.out_valid) begin
        chk("sb_has_word", 64'(sb.size() > 0), 64'(1));
        if (sb.size() > 0) begin
          fr = sb[0];
          chk("data_out", 64'(bus.data_out), 64'(fr.data));
          chk("corr_bits", 64'(bus.corr_bits), 64'(fr.corr));
          if (bus.out_ready) begin
            void'(sb.pop_front());
            acc_fault = acc_fault | fr.fault;
            if (fr.corr != 0 && cnt_m < 65535) cnt_m++;
            out_count++;
            last_data = bus.data_out;
            last_corr = bus.corr_bits;
            $display("out #%0d data=%h corr=%0d fault=%b cnt=%0d",
                     out_count, bus.data_out, bus.corr_bits, bus.copy_fault, bus.word_err_cnt);
          end
        end
      end
      if (bus.err_clr) begin
        acc_fault = '0;
        cnt_m = 0;
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.data_in, bus.bit_flip, bus.bypass));
    end
  end

  task automatic send_word(input logic [W-1:0] d, input logic [N*W-1:0] f, input logic b);
    bit took;
    int budget;
    bus.data_in = d;
    bus.bit_flip = f;
    bus.bypass = b;
    bus.in_valid = 1'b1;
    took = 1'b0;
    budget = 0;
    while (!took && budget < 20) begin
      @(negedge clk);
      took = bus.in_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    bus.in_valid = 1'b0;
    chk("accept", 64'(took), 64'(1));
  endtask

  task automatic wait_out(input int target);
    int b;
    b = 0;
    while (out_count < target && b < 50) begin
      @(posedge clk);
      #1;
      b++;
    end
    chk("out_count", 64'(out_count), 64'(target));
  endtask

  task automatic pulse_clr();
    bus.err_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.err_clr = 1'b0;
  endtask

  task automatic check_word(input string tag, input logic [W-1:0] d, input logic [4:0] c,
                            input logic [N-1:0] f, input int cnt);
    chk({tag, "_data"}, 64'(last_data), 64'(d));
    chk({tag, "_corr"}, 64'(last_corr), 64'(c));
    chk({tag, "_fault"}, 64'(bus.copy_fault), 64'(f));
    chk({tag, "_cnt"}, 64'(bus.word_err_cnt), 64'(cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] wv [4];
    int idx;
    int cyc;
    bit took;

    bus.in_valid = 1'b0; bus.data_in = '0; bus.bit_flip = '0; bus.bypass = 1'b0;
    bus.err_clr = 1'b0;  bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.data_in = '0; bus2.bit_flip = '0; bus2.bypass = 1'b0;
    bus2.err_clr = 1'b0;  bus2.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_data_out", 64'(bus.data_out), 64'(0));
    chk("rst_corr", 64'(bus.corr_bits), 64'(0));
    chk("rst_fault", 64'(bus.copy_fault), 64'(0));
    chk("rst_cnt", 64'(bus.word_err_cnt), 64'(0));

    // Clean word, plus 2-cycle latency.
    send_word(16'hA5A5, '0, 1'b0);
    chk("lat_early", 64'(bus.out_valid), 64'(0));
    @(posedge clk); #1;
    chk("lat_valid", 64'(bus.out_valid), 64'(1));
    wait_out(1);
    check_word("clean", 16'hA5A5, 5'd0, 3'b000, 0);

    // Copy 0 low byte flipped: corrected.
    send_word(16'h1234, 48'h0000_0000_00FF, 1'b0);
    wait_out(2);
    check_word("one_copy", 16'h1234, 5'd8, 3'b001, 1);

    pulse_clr();
    chk("clr_fault", 64'(bus.copy_fault), 64'(0));
    chk("clr_cnt", 64'(bus.word_err_cnt), 64'(0));

    // Same bit on two copies: miscorrected, copy 2 blamed.
    send_word(16'h0000, 48'h0000_0001_0001, 1'b0);
    wait_out(3);
    check_word("two_copy", 16'h0001, 5'd1, 3'b100, 1);

    // Bypass delivers corrupted copy 0 but reports against the vote.
    send_word(16'hFFFF, 48'h0000_0000_000F, 1'b1);
    wait_out(4);
    check_word("bypass", 16'hFFF0, 5'd4, 3'b101, 2);
    bus.bypass = 1'b0;
    bus.bit_flip = '0;
    pulse_clr();

    // Backpressure: 4 words against a stalled consumer.
    wv[0] = 16'h1111; wv[1] = 16'h2222; wv[2] = 16'h3333; wv[3] = 16'h4444;
    bus.out_ready = 1'b0;
    idx = 0;
    cyc = 0;
    bus.data_in = wv[0];
    bus.in_valid = 1'b1;
    while ((idx < 4 || cyc <= 5) && cyc < 40) begin
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (took) begin
        idx++;
        if (idx < 4) bus.data_in = wv[idx];
        else bus.in_valid = 1'b0;
      end
      if (cyc == 5) begin
        chk("bp_accepted", 64'(idx), 64'(2));
        chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
        chk("bp_out_valid", 64'(bus.out_valid), 64'(1));
        bus.out_ready = 1'b1;
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("bp_all_accepted", 64'(idx), 64'(4));
    wait_out(8);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_dup", 64'(out_count), 64'(8));
    chk("bp_last", 64'(last_data), 64'(16'h4444));

    // err_clr coincident with an erroneous output transfer.
    send_word(16'h5555, 48'h0000_0008_0000, 1'b0);
    @(posedge clk); #1;
    chk("clr_xfer_valid", 64'(bus.out_valid), 64'(1));
    bus.err_clr = 1'b1;
    @(posedge clk); #1;
    bus.err_clr = 1'b0;
    chk("clr_xfer_count", 64'(out_count), 64'(9));
    check_word("clr_xfer", 16'h5555, 5'd1, 3'b000, 0);
    bus.bit_flip = '0;

    // Reset while both stages are full and stalled.
    bus.out_ready = 1'b0;
    send_word(16'hAAAA, '0, 1'b0);
    send_word(16'hBBBB, '0, 1'b0);
    chk("stall_in_ready", 64'(bus.in_ready), 64'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_stall_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_stall_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_stall_data", 64'(bus.data_out), 64'(0));
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flush_count", 64'(out_count), 64'(9));

    // Narrow counter saturates: 5 erroneous words into CNT_W=2.
    bus2.bit_flip = 48'h0000_0000_0001;
    bus2.data_in = 16'h0F0F;
    bus2.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      $display("sat word %0d sent, cnt=%0d", i, bus2.word_err_cnt);
    end
    bus2.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("sat_cnt", 64'(bus2.word_err_cnt), 64'(3));
    chk("sat_data", 64'(bus2.data_out), 64'(16'h0F0F));
    chk("sat_fault", 64'(bus2.copy_fault), 64'(3'b001));

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tmr_codec_pipe.md
Name: tmr_codec_pipe

Overview:
- Parametrised, pipelined successor to the fixed 16-bit TMR coder/decoder pair.
- Replicates a DATA_W-bit word into N_COPIES copies and registers them.
- XORs a fault-injection mask onto the replicated word, then majority-votes per bit back to DATA_W.
- Adds valid/ready flow control, per-word correction reporting, sticky per-copy fault map, saturating error counter and a vote-bypass mode; used for fault-injection power/reliability evaluation.

Parameters:
- DATA_W, 16: payload width in bits (>=1).
- N_COPIES, 3: replica count; odd, 3..7.
- CNT_W, 16: width of the error-word counter.

Ports:
- clk  input  1  single clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept the input word this cycle.
- data_in  input  DATA_W  payload.
- bit_flip  input  N_COPIES*DATA_W  fault mask; copy k occupies bits [k*DATA_W +: DATA_W].
- bypass  input  1  1 = output copy 0 unvoted.
- err_clr  input  1  clears copy_fault and word_err_cnt.
- out_valid  output  1  output word valid.
- out_ready  input  1  consumer accepts output.
- data_out  output  DATA_W  voted (or bypassed) word.
- corr_bits  output  clog2(DATA_W+1)  number of bit positions with any copy disagreement, for the word on data_out.
- copy_fault  output  N_COPIES  sticky; bit k set once copy k has differed from the vote.
- word_err_cnt  output  CNT_W  saturating count of delivered words with corr_bits != 0.

Behaviour:
- Two register stages: S1 holds the replicated word; S2 holds the vote result. Each stage has a valid flag.
- Handshakes:
  - s2_free = !s2_valid | out_ready.
  - in_ready = !s1_valid | s2_free (combinational).
  - An input transfer occurs when in_valid & in_ready; an output transfer occurs when out_valid & out_ready.
- S1 load: on an input transfer, each copy k is loaded with data_in and s1_valid is set. Otherwise, if s1 advances to S2, s1_valid is cleared.
- S1 -> S2 advance: occurs when s1_valid & s2_free.
  - Corrupted copy k = S1 copy k XOR bit_flip slice k, with bit_flip sampled in the advance cycle only.
  - Vote bit i = 1 iff popcount over copies of bit i > N_COPIES/2.
  - corr_bits = count of positions where the corrupted copies are not all equal.
  - With bypass=1, data_out is corrupted copy 0. corr_bits, copy_fault and the counter are still computed against the vote.
  - If S2 holds a word with out_ready=0 and S1 is full, both stages hold and in_ready=0. No data loss or duplication.
- Latency: 2 cycles from input transfer to out_valid when out_ready stays high. Full throughput is 1 word/cycle.
- copy_fault[k]:
  - Set on the S1->S2 advance if corrupted copy k != vote.
  - Updated with OR; it never clears except via err_clr or rst.
- word_err_cnt:
  - Increments by 1 on each output transfer whose corr_bits != 0.
  - Saturates at all-ones.
- err_clr:
  - Zeroes copy_fault and word_err_cnt in the cycle it is applied.
  - Clear wins over a same-cycle set or increment.
  - Pipeline data is unaffected.
- Reset (rst=1 at a clock edge):
  - s1_valid, s2_valid, out_valid, data_out, corr_bits, copy_fault and word_err_cnt all become 0.
  - In-flight words are discarded, including mid-stall.
  - in_ready reads 1 from the first cycle after reset.
- Vote is exact when at most (N_COPIES-1)/2 copies flip a given bit. Beyond that, data_out is silently wrong; corr_bits still reports the disagreement.

Test Plan:
- Defaults, out_ready=1: data_in=16'hA5A5, bit_flip=0 -> 2 cycles later data_out=16'hA5A5, corr_bits=0, copy_fault=3'b000, word_err_cnt=0.
- data_in=16'h1234, bit_flip=48'h0000_0000_00FF (copy 0, low byte flipped) -> data_out=16'h1234, corr_bits=8, copy_fault=3'b001, word_err_cnt=1.
- Same bit on two copies: data_in=16'h0000, bit_flip=48'h0000_0001_0001 -> data_out=16'h0001 (miscorrected), corr_bits=1, copy_fault=3'b100.
- bypass=1, data_in=16'hFFFF, bit_flip copy 0 = 16'h000F -> data_out=16'hFFF0, corr_bits=4.
- Backpressure: stream 4 words with out_ready=0 -> in_ready drops after 2 accepted. Then assert out_ready -> all 4 words delivered in order, no duplicates.
- CNT_W=2, 5 erroneous words -> word_err_cnt sticks at 3.
- Same cycle as an erroneous output transfer, pulse err_clr -> counter and copy_fault read 0.
- Assert rst while stalled -> out_valid=0 and in_ready=1 next cycle.
